load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter MEM_AW, 6: data-memory word-address width (64 words x 32 bits).
REQ-002 Parameter TIMEOUT, 15: maximum cycles in REQ+WAIT before an error response; legal range 1..255.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ld_valid  in  1  load request from the execute stage.
REQ-006 ld_ready  out  1  unit accepts a request.
REQ-007 ld_addr  in  32  byte address.
REQ-008 ld_funct3  in  3  RV32I load type.
REQ-009 ld_rd  in  5  destination register index.
REQ-010 mem_req  out  1  memory read request.
REQ-011 mem_addr  out  MEM_AW  word address, equal to latched addr[MEM_AW+1:2].
REQ-012 mem_gnt  in  1  memory accepted mem_req.
REQ-013 mem_rvalid  in  1  read data valid.
REQ-014 mem_rdata  in  32  read word.
REQ-015 wb_valid  out  1  writeback result valid.
REQ-016 wb_ready  in  1  writeback consumer accepts the result.
REQ-017 wb_rd  out  5  destination index of the result.
REQ-018 wb_data  out  32  formatted load data.
REQ-019 wb_err  out  1  result is an error; wb_data is 0.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT and RESP; ld_ready=1 only in IDLE, mem_req=1 only in REQ, and wb_valid=1 only in RESP.
REQ-021 The ld_valid&&ld_ready edge SHALL latch addr, funct3 and rd, then go to REQ, or go directly to RESP with wb_err=1 on an error per REQ-022/023/032.
REQ-022 funct3 011, 110 or 111 SHALL produce an error response with no memory request.
REQ-023 addr[31:MEM_AW+2] nonzero SHALL produce an error response with no memory request.
REQ-024 REQ: hold mem_req and mem_addr stable until mem_gnt, then go to WAIT; mem_rvalid is ignored in REQ.
REQ-025 WAIT: on mem_rvalid, register the formatted data and go to RESP; mem_rvalid in IDLE or RESP is ignored.
REQ-026 Formatting SHALL be as follows.
- LB/LBU: byte lane addr[1:0], sign- or zero-extended.
- LH/LHU: half lane addr[1], sign- or zero-extended.
- LW: full word.
REQ-027 Timeout counter: clear on entering REQ and increment each REQ/WAIT cycle; on reaching TIMEOUT, go to RESP with wb_err=1 and wb_data=0.
REQ-028 RESP: hold wb_valid, wb_rd, wb_data and wb_err stable until wb_ready, then go to IDLE; wb_valid&&wb_ready and a new ld_valid are never serviced in the same cycle.
REQ-029 Minimum latency (gnt in the first REQ cycle, rvalid in the first WAIT cycle): wb_valid is high 3 cycles after the accept edge; maximum throughput is 1 load per 4 cycles.

Reset
REQ-030 Reset SHALL force IDLE, clear the counter and latches, and set ld_ready=1, mem_req=0, mem_addr=0, wb_valid=0, wb_rd=0, wb_data=0, wb_err=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid after release produces no writeback.

Configuration
REQ-032 Macro LOAD_UNIT_MISALIGN_CHECK_EN controls misalignment handling.
- Defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, produces an error response with no memory request.
- Undefined: ignore low address bits beyond the access size (LH uses lane addr[1]; LW uses the whole word); no misalignment errors.

Verification
REQ-033 mem[5]=0x8899AABB; LB addr 0x17, rd=3, gnt and rvalid immediate -> wb_valid 3 cycles after accept, wb_rd=3, wb_data=0xFFFFFF88.
REQ-034 Same word; LHU addr 0x14, gnt after 2 cycles, rvalid after 3, wb_ready low for 2 RESP cycles -> wb_data=0x0000AABB held stable until wb_ready.
REQ-035 LW addr 0x100 (out of range) -> no mem_req, wb_err=1, wb_data=0; funct3=011 gives the same.
REQ-036 LW addr 0x16, run once with and once without the macro -> with: wb_err=1 and no mem_req; without: mem_addr=5, wb_data=0x8899AABB.
REQ-037 mem_gnt held low -> wb_err=1 exactly TIMEOUT cycles after entering REQ; reset asserted in WAIT and then a late rvalid -> IDLE with no wb_valid.

Source files
------------

// File: rtl/load_unit.sv
// RV32I load unit: one outstanding load, word memory port with grant/rvalid, timeout and error responses.
// Optional LOAD_UNIT_MISALIGN_CHECK_EN turns misaligned LH/LHU/LW into error responses.
module load_unit #(
  parameter int MEM_AW  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [2:0]        ld_funct3,
  input  logic [4:0]        ld_rd,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready
  // (ld_valid/ld_ready, mem_req/mem_gnt, wb_valid/wb_ready); the source holds
  // its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [MEM_AW+1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic [7:0]        cnt_q;
  logic              bad_funct3, out_of_range, misalign, req_err, cnt_last;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] a,
                                      input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b100:  fmt = {24'd0, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b101:  fmt = {16'd0, h};
      default: fmt = w;
    endcase
  endfunction

  assign bad_funct3   = (ld_funct3 == 3'b011) || (ld_funct3 == 3'b110) || (ld_funct3 == 3'b111);
  assign out_of_range = (ld_addr[31:MEM_AW+2] != '0);
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
  assign misalign = (((ld_funct3 == 3'b001) || (ld_funct3 == 3'b101)) && ld_addr[0]) ||
                    ((ld_funct3 == 3'b010) && (ld_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign req_err  = bad_funct3 || out_of_range || misalign;
  assign cnt_last = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Timeout wins over a grant in the final REQ cycle so REQ+WAIT never exceeds
  // TIMEOUT cycles; data arriving in the final WAIT cycle is still accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ld_valid) state_d = req_err ? RESP : REQ;
      REQ:  if (cnt_last) state_d = RESP;
            else if (mem_gnt) state_d = WAIT;
      WAIT: if (mem_rvalid || cnt_last) state_d = RESP;
      RESP: if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = (state_q == IDLE);
    mem_req   = (state_q == REQ);
    wb_valid  = (state_q == RESP);
    mem_addr  = addr_q[MEM_AW+1:2];
    wb_rd     = rd_q;
    wb_data   = data_q;
    wb_err    = err_q;
    dbg_state = state_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (ld_valid) begin
          addr_q   <= ld_addr[MEM_AW+1:0];
          funct3_q <= ld_funct3;
          rd_q     <= ld_rd;
          data_q   <= '0;
          err_q    <= req_err;
          cnt_q    <= '0;
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_last) begin
            err_q  <= 1'b1;
            data_q <= '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid) begin
            data_q <= fmt(mem_rdata, addr_q[1:0], funct3_q);
            err_q  <= 1'b0;
          end else if (cnt_last) begin
            err_q  <= 1'b1;
            data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: formatting, stalls, error responses, timeout and mid-transaction reset.
module tb_load_unit;
  localparam int MEM_AW  = 6;
  localparam int TIMEOUT = 15;

  logic              clk, reset;
  logic              ld_valid, ld_ready;
  logic [31:0]       ld_addr;
  logic [2:0]        ld_funct3;
  logic [4:0]        ld_rd;
  logic              mem_req, mem_gnt, mem_rvalid;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              wb_valid, wb_ready, wb_err;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic [1:0]        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  load_unit #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_rd(ld_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: all driving and sampling happens on the falling edge
  task automatic issue(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    ld_valid  = 1'b1;
    ld_addr   = addr;
    ld_funct3 = f3;
    ld_rd     = rd;
    @(negedge clk);
    ld_valid  = 1'b0;
    ld_addr   = 32'hDEAD_BEEF;
  endtask

  task automatic mem_serve(input int gnt_wait, input int rv_wait, input logic [MEM_AW-1:0] exp_addr,
                           input logic [31:0] word);
    for (int i = 0; i < gnt_wait; i++) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("req_addr", {26'd0, mem_addr}, {26'd0, exp_addr});
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    chk("req_addr_gnt", {26'd0, mem_addr}, {26'd0, exp_addr});
    chk("req_at_gnt", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < rv_wait; i++) begin
      chk("wait_no_req", {31'd0, mem_req}, 32'd0);
      chk("wait_no_wb", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
    end
    chk("wait_no_wb", {31'd0, wb_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // scoreboard for one writeback; a new ld_valid rides along with wb_ready
  task automatic expect_resp(input string tag, input logic [4:0] rd, input logic [31:0] data,
                             input logic err, input int ready_wait);
    for (int i = 0; i <= ready_wait; i++) begin
      chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
      chk({tag, "_data"}, wb_data, data);
      chk({tag, "_err"}, {31'd0, wb_err}, {31'd0, err});
      chk({tag, "_no_ready"}, {31'd0, ld_ready}, 32'd0);
      if (i < ready_wait) @(negedge clk);
    end
    wb_ready  = 1'b1;
    ld_valid  = 1'b1;
    ld_addr   = 32'h14;
    ld_funct3 = 3'b010;
    @(negedge clk);
    wb_ready = 1'b0;
    ld_valid = 1'b0;
    chk({tag, "_done"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, ld_ready}, 32'd1);
    chk({tag, "_no_overlap"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // LB 0x17, immediate gnt/rvalid: RESP in the third cycle after accept
    issue(32'h17, 3'b000, 5'd3);
    mem_serve(0, 0, 6'd5, 32'h8899_AABB);
    expect_resp("lb", 5'd3, 32'hFFFF_FF88, 1'b0, 0);

    // LHU 0x14 with slow memory and stalled consumer
    issue(32'h14, 3'b101, 5'd7);
    mem_serve(2, 3, 6'd5, 32'h8899_AABB);
    expect_resp("lhu", 5'd7, 32'h0000_AABB, 1'b0, 2);

    issue(32'h16, 3'b001, 5'd8);
    mem_serve(0, 1, 6'd5, 32'h8899_AABB);
    expect_resp("lh_hi", 5'd8, 32'hFFFF_8899, 1'b0, 0);

    issue(32'h15, 3'b100, 5'd9);
    mem_serve(1, 0, 6'd5, 32'h8899_AABB);
    expect_resp("lbu", 5'd9, 32'h0000_00AA, 1'b0, 0);

    issue(32'hFC, 3'b000, 5'd10);
    mem_serve(0, 0, 6'd63, 32'h0000_007F);
    expect_resp("lb_pos", 5'd10, 32'h0000_007F, 1'b0, 0);

    issue(32'h14, 3'b010, 5'd11);
    mem_serve(0, 0, 6'd5, 32'h8899_AABB);
    expect_resp("lw", 5'd11, 32'h8899_AABB, 1'b0, 1);

    // immediate error responses: no memory request
    issue(32'h100, 3'b010, 5'd12);
    chk("oor_no_req", {31'd0, mem_req}, 32'd0);
    expect_resp("oor", 5'd12, 32'd0, 1'b1, 0);
    issue(32'h14, 3'b011, 5'd13);
    chk("f3_011_no_req", {31'd0, mem_req}, 32'd0);
    expect_resp("f3_011", 5'd13, 32'd0, 1'b1, 0);
    issue(32'h14, 3'b111, 5'd14);
    expect_resp("f3_111", 5'd14, 32'd0, 1'b1, 0);

    // misaligned LW
    issue(32'h16, 3'b010, 5'd15);
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
    chk("mis_no_req", {31'd0, mem_req}, 32'd0);
    expect_resp("mis_lw", 5'd15, 32'd0, 1'b1, 0);
`else
    mem_serve(0, 0, 6'd5, 32'h8899_AABB);
    expect_resp("mis_lw", 5'd15, 32'h8899_AABB, 1'b0, 0);
`endif

    // timeout: gnt never arrives
    issue(32'h20, 3'b010, 5'd4);
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
    end
    expect_resp("timeout", 5'd4, 32'd0, 1'b1, 0);

    // reset in WAIT, then a late rvalid
    issue(32'h14, 3'b010, 5'd2);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("pre_rst_wait", {30'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_idle", {31'd0, ld_ready}, 32'd1);
    chk("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rv_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("late_rv_idle", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    chk("late_rv_no_wb2", {31'd0, wb_valid}, 32'd0);

    // recovery after reset
    issue(32'h14, 3'b001, 5'd21);
    mem_serve(0, 0, 6'd5, 32'h8899_AABB);
    expect_resp("post_rst", 5'd21, 32'hFFFF_AABB, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
